// File: rtl/periph_pkg.sv
// Shared types and constants for the peripheral input controller slice.
package periph_pkg;

  // Controller sequencing states; encoding is fixed so debug probes stay stable.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DELIVER      = 2'd3
  } pic_state_t;

  // Debounce length suitable for simulation; the board build overrides it (~500000).
  localparam int unsigned DEFAULT_DEBOUNCE = 4;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for one board button.
// Emits single-cycle press / release pulses on debounced level changes.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           btn_sync;
  logic                 btn_s;
  logic                 btn_db;
  logic [CNT_WIDTH-1:0] cnt;

  assign btn_s = btn_sync[1];

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_sync <= '0;
    end else begin
      btn_sync <= {btn_sync[0], button_raw};
    end
  end

  // Count consecutive cycles of disagreement; any bounce back restarts the count.
  // The pulses are registered alongside the level toggle so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_db        <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (btn_s == btn_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_db        <= ~btn_db;
        cnt           <= '0;
        press_pulse   <= ~btn_db;
        release_pulse <= btn_db;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/peripheral_input_controller.sv
// Sequences a peripheral-read instruction against a confirm button and a switch
// bank: stalls the core, captures switches on press, delivers on release.
module peripheral_input_controller
  import periph_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  input_request,
  input  logic                  button_raw,
  input  logic [DATA_WIDTH-1:0] switches_raw,
  output logic                  halt_temporarily_signal,
  output logic [DATA_WIDTH-1:0] peripheral_value,
  output logic                  peripheral_valid,
  output logic                  busy
);

  pic_state_t            state;
  logic [DATA_WIDTH-1:0] sw_meta;
  logic [DATA_WIDTH-1:0] sw_s;
  logic                  press;
  logic                  btn_release;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_confirm_button (
    .clock         (clock),
    .reset         (reset),
    .button_raw    (button_raw),
    .press_pulse   (press),
    .release_pulse (btn_release)
  );

  // Synchronise the quasi-static switch bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= switches_raw;
      sw_s    <= sw_meta;
    end
  end

  // Capture the switches on the press edge, even if the request is dropped
  // in that same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      peripheral_value <= '0;
    end else if (state == WAIT_PRESS && press) begin
      peripheral_value <= sw_s;
    end
  end

  // Transaction sequencer; busy and valid are registered with the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      peripheral_valid <= 1'b0;
    end else begin
      peripheral_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (input_request) begin
            state <= WAIT_PRESS;
            busy  <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          if (!input_request) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (press) begin
            state <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!input_request) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (btn_release) begin
            state            <= DELIVER;
            busy             <= 1'b0;
            peripheral_valid <= 1'b1;
          end
        end
        DELIVER: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stall the core from the very cycle the request is decoded until delivery.
  always_comb begin
    halt_temporarily_signal = (state == IDLE && input_request) ||
                              (state == WAIT_PRESS) ||
                              (state == WAIT_RELEASE);
  end

endmodule
